// File: rtl/mono_pulse_arbiter.sv
// Shared one-shot pulse generator: NREQ requesters fire on a rising request
//    edge, the timer is granted round-robin, and a recovery gap follows each pulse.
// Latency: request edge -> pending at that clock edge -> q high after the next.
// Backpressure: none; a request arriving while its pending bit is set coalesces.
// Ports:
//    clk_i, clr_i        rising-edge clock, asynchronous active-high clear
//    req_i  [NREQ]       triggers (rising edge)      len_i [NREQ*WIDTH] pulse lengths
//    abort_i             ends the active pulse early (no done)
//    q_o / q_n_o         pulse output and its complement
//    gnt_o  [NREQ]       one-hot owner while pulsing  done_o [NREQ] normal-completion strobe
//    busy_o              not idle
module mono_pulse_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int GAP   = 2
) (
   input  logic                    clk_i,
   input  logic                    clr_i,
   input  logic [NREQ-1:0]         req_i,
   input  logic [NREQ*WIDTH-1:0]   len_i,
   input  logic                    abort_i,
   output logic                    q_o,
   output logic                    q_n_o,
   output logic [NREQ-1:0]         gnt_o,
   output logic [NREQ-1:0]         done_o,
   output logic                    busy_o
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_RECOVER} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   req_q;
   logic [NREQ-1:0]   pend_q, pend_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     own_q, own_d;
   logic [WIDTH-1:0]  cnt_q, cnt_d;
   logic [7:0]        rcnt_q, rcnt_d;

   logic [NREQ-1:0]   trig;
   logic [NREQ-1:0]   own_oh;
   logic [IW-1:0]     sel;
   logic              sel_vld;
   logic [WIDTH-1:0]  sel_len;
   logic [WIDTH-1:0]  own_len;

   // Counter load value: a zero length still yields a one-cycle pulse.
   function automatic logic [WIDTH-1:0] load_val(input logic [WIDTH-1:0] l);
      return (l == '0) ? '0 : l - 1'b1;
   endfunction

   assign trig    = req_i & ~req_q;
   assign own_oh  = {{(NREQ-1){1'b0}}, 1'b1} << own_q;
   assign sel_len = len_i[int'(sel)*WIDTH +: WIDTH];
   assign own_len = len_i[int'(own_q)*WIDTH +: WIDTH];

   // Round-robin pick: first pending bit at or above ptr, wrapping.
   always_comb begin
      int idx;
      idx     = 0;
      sel     = '0;
      sel_vld = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!sel_vld && pend_q[idx]) begin
            sel_vld = 1'b1;
            sel     = IW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      done_d  = '0;

      unique case (state_q)
         S_IDLE: begin
            pend_d = pend_q | trig;
            if (sel_vld) begin
               pend_d[sel] = 1'b0;
               own_d       = sel;
               cnt_d       = load_val(sel_len);
               ptr_d       = (int'(sel) == NREQ-1) ? '0 : sel + 1'b1;
               state_d     = S_PULSE;
            end
         end

         S_PULSE: begin
            // The owner's own trigger is a retrigger, never a pending request.
            pend_d = pend_q | (trig & ~own_oh);
            // Priority: abort > retrigger > natural end.
            if (abort_i || (!trig[own_q] && cnt_q == '0)) begin
               if (!abort_i) done_d = own_oh;
               if (GAP == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_RECOVER;
                  rcnt_d  = 8'(GAP - 1);
               end
            end else if (trig[own_q]) begin
               cnt_d = load_val(own_len);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_RECOVER: begin
            pend_d = pend_q | trig;
            if (rcnt_q == '0) state_d = S_IDLE;
            else              rcnt_d  = rcnt_q - 1'b1;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge clr_i) begin
      if (clr_i) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         pend_q  <= '0;
         done_q  <= '0;
         ptr_q   <= '0;
         own_q   <= '0;
         cnt_q   <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_i;
         pend_q  <= pend_d;
         done_q  <= done_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         cnt_q   <= cnt_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // q is decoded straight from the state register so clr drops it at once.
   assign q_o    = (state_q == S_PULSE);
   assign q_n_o  = ~q_o;
   assign gnt_o  = q_o ? own_oh : '0;
   assign done_o = done_q;
   assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_mono_pulse_arbiter.sv
// Directed bench for mono_pulse_arbiter: one instance with GAP=2 and one with
//    GAP=0 share all inputs; expected values are hand-derived per scenario.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mono_pulse_arbiter;

   logic        clk;
   logic        clr;
   logic [3:0]  req;
   logic [31:0] len_v;
   logic        abort;

   logic        q, q_n, busy;
   logic [3:0]  gnt, done;
   logic        q_z, q_n_z, busy_z;
   logic [3:0]  gnt_z, done_z;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] g_seen [8];
   int         w_seen [8];
   int         gap_seen [8];
   int         n_seen;
   int         done_cnt;

   mono_pulse_arbiter #(.NREQ(4), .WIDTH(8), .GAP(2)) dut (
      .clk_i(clk), .clr_i(clr), .req_i(req), .len_i(len_v), .abort_i(abort),
      .q_o(q), .q_n_o(q_n), .gnt_o(gnt), .done_o(done), .busy_o(busy)
   );

   mono_pulse_arbiter #(.NREQ(4), .WIDTH(8), .GAP(0)) dut_g0 (
      .clk_i(clk), .clr_i(clr), .req_i(req), .len_i(len_v), .abort_i(abort),
      .q_o(q_z), .q_n_o(q_n_z), .gnt_o(gnt_z), .done_o(done_z), .busy_o(busy_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      tick();
      tick();
      clr = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      tick();
      while ((busy || busy_z) && n < 600) begin
         tick();
         n++;
      end
      chk("idle_reached", {31'b0, busy | busy_z}, 32'd0);
   endtask

   // Counts consecutive q-high samples starting at the current sample.
   task automatic count_high(output int w, output int nd);
      w  = 0;
      nd = 0;
      while (q && w < 400) begin
         if (done != 4'b0) nd++;
         w++;
         tick();
      end
   endtask

   // Records every pulse of the GAP=2 instance over a fixed window.
   task automatic collect(input int cycles);
      logic prev_q;
      int   low_run;
      n_seen   = 0;
      done_cnt = 0;
      prev_q   = q;
      low_run  = 0;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (done != 4'b0) done_cnt++;
         if (q && !prev_q && n_seen < 8) begin
            g_seen[n_seen]   = gnt;
            gap_seen[n_seen] = low_run;
            w_seen[n_seen]   = 0;
            n_seen++;
         end
         if (q) begin
            if (n_seen > 0) w_seen[n_seen-1]++;
            low_run = 0;
         end else begin
            low_run++;
         end
         prev_q = q;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, nd;
      logic flag;

      clr   = 1'b1;
      req   = 4'b0;
      abort = 1'b0;
      len_v = 32'h0;
      #2;
      chk("rst_q",    {31'b0, q},    32'd0);
      chk("rst_qn",   {31'b0, q_n},  32'd1);
      chk("rst_gnt",  {28'b0, gnt},  32'd0);
      chk("rst_done", {28'b0, done}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      tick();
      clr = 1'b0;
      tick();

      // Single request, len0=5.
      len_v = {8'd0, 8'd0, 8'd0, 8'd5};
      req   = 4'b0001;
      tick();                                          // edge k: pending
      chk("t1_wait_q",    {31'b0, q},    32'd0);
      chk("t1_wait_busy", {31'b0, busy}, 32'd0);
      tick();                                          // k+1: pulse starts
      chk("t1_q_on", {31'b0, q},   32'd1);
      chk("t1_gnt",  {28'b0, gnt}, 32'h1);
      req = 4'b0;
      repeat (4) tick();                               // k+5
      chk("t1_q_last", {31'b0, q}, 32'd1);
      tick();                                          // k+6
      chk("t1_q_off", {31'b0, q},    32'd0);
      chk("t1_qn",    {31'b0, q_n},  32'd1);
      chk("t1_done",  {28'b0, done}, 32'h1);
      chk("t1_gnt0",  {28'b0, gnt},  32'h0);
      tick();                                          // k+7
      chk("t1_done_clr", {28'b0, done}, 32'h0);
      chk("t1_busy_rec", {31'b0, busy}, 32'd1);
      tick();                                          // k+8
      chk("t1_busy_off", {31'b0, busy}, 32'd0);

      // Round robin from ptr=0: grants 0,1,3 then ptr back to 0.
      do_reset();
      len_v = {8'd3, 8'd3, 8'd3, 8'd3};
      req   = 4'b1011;
      collect(40);
      chk("rr_npulse", n_seen, 3);
      chk("rr_g0", {28'b0, g_seen[0]}, 32'h1);
      chk("rr_g1", {28'b0, g_seen[1]}, 32'h2);
      chk("rr_g2", {28'b0, g_seen[2]}, 32'h8);
      for (int i = 0; i < 3; i++) chk($sformatf("rr_w%0d", i), w_seen[i], 3);
      chk("rr_gap1", gap_seen[1], 3);
      chk("rr_gap2", gap_seen[2], 3);
      chk("rr_done", done_cnt, 3);
      req = 4'b0;
      tick();
      req = 4'b0101;
      collect(30);
      chk("rr_ptr_n",  n_seen, 2);
      chk("rr_ptr_g0", {28'b0, g_seen[0]}, 32'h1);
      chk("rr_ptr_g1", {28'b0, g_seen[1]}, 32'h4);
      req = 4'b0;
      wait_idle();

      // Retrigger two cycles into a len=4 pulse.
      len_v = {8'd0, 8'd4, 8'd0, 8'd0};
      req = 4'b0100;
      tick();
      tick();                                          // g
      chk("rt_gnt", {28'b0, gnt}, 32'h4);
      req = 4'b0;
      tick();                                          // g+1
      req = 4'b0100;
      tick();                                          // g+2 retrigger
      req = 4'b0;
      count_high(w, nd);
      chk("rt_w_rest", w, 4);
      chk("rt_done_in_pulse", nd, 0);
      chk("rt_done", {28'b0, done}, 32'h4);
      wait_idle();

      // Retrigger landing on the cnt==0 edge.
      req = 4'b0100;
      tick();
      tick();                                          // g
      req = 4'b0;
      repeat (3) tick();                               // g+3
      req = 4'b0100;
      tick();                                          // g+4
      req = 4'b0;
      chk("rt0_q_ext",   {31'b0, q},    32'd1);
      chk("rt0_no_done", {28'b0, done}, 32'h0);
      count_high(w, nd);
      chk("rt0_w_rest", w, 4);
      chk("rt0_done", {28'b0, done}, 32'h4);
      wait_idle();

      // Abort together with an owner retrigger; req[0] pending meanwhile.
      len_v = {8'd0, 8'd0, 8'd10, 8'd2};
      req = 4'b0010;
      tick();
      tick();                                          // g
      chk("ab_gnt", {28'b0, gnt}, 32'h2);
      req = 4'b0001;
      tick();                                          // g+1
      req = 4'b0;
      tick();                                          // g+2
      req   = 4'b0010;
      abort = 1'b1;
      tick();                                          // g+3
      abort = 1'b0;
      req   = 4'b0;
      chk("ab_q",    {31'b0, q},    32'd0);
      chk("ab_done", {28'b0, done}, 32'h0);
      chk("ab_busy", {31'b0, busy}, 32'd1);
      tick();                                          // g+4
      chk("ab_rec_q", {31'b0, q},    32'd0);
      chk("ab_rec_d", {28'b0, done}, 32'h0);
      tick();                                          // g+5
      chk("ab_idle", {31'b0, busy}, 32'd0);
      tick();                                          // g+6
      chk("ab_pend_gnt", {28'b0, gnt}, 32'h1);
      count_high(w, nd);
      chk("ab_pend_w", w, 2);
      chk("ab_pend_done", {28'b0, done}, 32'h1);
      wait_idle();

      // len=0 gives one cycle; len=255 runs the full count without wrap.
      len_v = {8'd0, 8'd255, 8'd0, 8'd0};
      req = 4'b1000;
      tick();
      tick();
      req = 4'b0;
      count_high(w, nd);
      chk("len0_w",    w, 1);
      chk("len0_done", {28'b0, done}, 32'h8);
      wait_idle();
      req = 4'b0100;
      tick();
      tick();
      req = 4'b0;
      count_high(w, nd);
      chk("len255_w",    w, 255);
      chk("len255_done", {28'b0, done}, 32'h4);
      wait_idle();

      // GAP=0: the next pending grant comes one cycle after q falls.
      do_reset();
      len_v = {8'd0, 8'd0, 8'd2, 8'd2};
      req = 4'b0011;
      tick();
      tick();                                          // g
      req = 4'b0;
      chk("g0_gnt_a", {28'b0, gnt_z}, 32'h1);
      tick();
      chk("g0_q_a2", {31'b0, q_z}, 32'd1);
      tick();                                          // g+2
      chk("g0_q_low",  {31'b0, q_z},    32'd0);
      chk("g0_done_a", {28'b0, done_z}, 32'h1);
      chk("g0_idle",   {31'b0, busy_z}, 32'd0);
      tick();                                          // g+3
      chk("g0_gnt_b", {28'b0, gnt_z}, 32'h2);
      wait_idle();

      // Asynchronous clear mid-pulse; req[2] held high through release.
      len_v = {8'd0, 8'd1, 8'd10, 8'd0};
      req = 4'b0010;
      tick();
      tick();
      req = 4'b0011;                                   // req[0] goes pending
      tick();
      tick();
      chk("ar_pre_q", {31'b0, q}, 32'd1);
      #2;
      clr = 1'b1;
      req = 4'b0100;
      #1;
      chk("ar_q",    {31'b0, q},    32'd0);
      chk("ar_qn",   {31'b0, q_n},  32'd1);
      chk("ar_gnt",  {28'b0, gnt},  32'h0);
      chk("ar_busy", {31'b0, busy}, 32'd0);
      chk("ar_done", {28'b0, done}, 32'h0);
      tick();
      clr = 1'b0;
      tick();                                          // release edge 1
      chk("ar_rel1_q", {31'b0, q}, 32'd0);
      tick();                                          // release edge 2
      chk("ar_rel2_q",   {31'b0, q},   32'd1);
      chk("ar_rel2_gnt", {28'b0, gnt}, 32'h4);
      count_high(w, nd);
      chk("ar_w", w, 1);
      req  = 4'b0;
      flag = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (q) flag = 1'b1;
      end
      chk("ar_pend_lost", {31'b0, flag}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mono_pulse_arbiter.md
# mono_pulse_arbiter

Clocked, synchronous replacement for a shared retriggerable monostable (LS123-style one-shot). It lets NREQ requesters share one pulse generator. Each requester fires a pulse with a rising edge on its request line; the block grants the timer round-robin, times a programmable pulse width in clock cycles, and enforces a recovery gap. It sits between request-generating glue logic and the one-shot output net (q/q_), replacing RC timing with cycle-exact counting.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: pulse-length counter width in bits.
- GAP, 2: recovery cycles forced low between pulses (0..255; 0 = no recovery state).
- clk  in  1  rising-edge clock.
- clr  in  1  reset clr, asynchronous, active-high.
- req  in  NREQ  per-requester trigger; rising edge (sampled on clk) = trigger.
- len  in  NREQ*WIDTH  packed pulse lengths; requester i uses len[i*WIDTH +: WIDTH].
- abort  in  1  synchronous; terminates the active pulse early.
- q  out  1  pulse output, high while the pulse is active.
- q_  out  1  always ~q.
- gnt  out  NREQ  one-hot owner of the active pulse; 0 when not in PULSE.
- done  out  NREQ  one-cycle strobe when requester i's pulse completes normally.
- busy  out  1  high whenever state != IDLE.

## Operation
- Edge detect: req_d registers req. At an edge where req[i] & ~req_d[i], the cycle holds a trigger for i.
- Pending: a trigger for a non-owner sets pend[i]. A repeated trigger while pend[i] is already set coalesces (no count).
- States: IDLE, PULSE, RECOVER.
- IDLE, pend != 0:
  - Pick the first set pend bit searching from ptr upward, with wrap.
  - At that edge: q=1, gnt=onehot(i), cnt=max(len_i,1)-1, pend[i]=0, ptr=(i+1) mod NREQ, go to PULSE.
  - len=0 is treated as 1.
- PULSE:
  - cnt decrements each cycle.
  - When cnt==0 at an edge: q=0, gnt=0, done[i]=1 for that cycle. Go to RECOVER with rcnt=GAP-1, or to IDLE if GAP=0.
- Retrigger: an owner trigger in PULSE reloads cnt=max(len_i,1)-1. The pulse then ends len_i cycles after the retriggering edge. pend is not set.
- abort in PULSE: q=0, gnt=0, no done. Go to RECOVER (or IDLE if GAP=0). abort is ignored in IDLE and RECOVER.
- RECOVER:
  - q stays low; rcnt decrements.
  - At rcnt==0, go to IDLE.
  - Triggers from any requester, including the previous owner, set pend.
- len is sampled only at grant and at retrigger; changes at other times have no effect.

## Timing
- Reset (clr=1, async): q=0, q_=1, gnt=0, done=0, busy=0, pend=0, ptr=0, req_d=0, cnt=0, state=IDLE.
- After release, a req already high produces a trigger at the first clock edge.
- Latency, idle block:
  - req rises before edge k.
  - pend set at edge k.
  - q high after edge k+1.
- Pulse width: exactly max(len,1) cycles of q=1 without retrigger or abort.
- Minimum low time between consecutive pulses: GAP cycles in RECOVER plus 1 arbitration cycle in IDLE.
- done is coincident with the first q=0 cycle.
- Simultaneous events at one edge:
  - abort beats retrigger and beats cnt==0 (no done).
  - Retrigger beats cnt==0 (pulse extends, no done).
  - Triggers from other requesters at that edge still set pend.
- clr asserted mid-pulse: q drops immediately (asynchronously); no done; all pending requests are lost.
- ptr always advances past the last grant, so no requester waits more than NREQ-1 pulses.

## Test plan
- Single request: NREQ=4, GAP=2, len0=5; rise req[0] before edge 10 -> pend at edge 10; q=1 for edges 11..15 (5 cycles), gnt=0001; done[0] for 1 cycle after edge 16; busy low after edge 18.
- Round-robin fairness: req[3], req[1], req[0] all rise at the same edge with ptr=0; len=3 each -> grants in order 0,1,3; ptr ends at 0; every gap between pulses is ≥3 cycles.
- Retrigger: len2=4; retrigger req[2] 2 cycles into the pulse -> q high 6 cycles total, exactly one done[2]; same retrigger on the cnt==0 edge -> pulse extends, done is deferred.
- Abort precedence: len1=10; abort and a retrigger of req[1] at the same edge, cycle 4 -> q falls after that edge, no done, RECOVER for GAP cycles; a req[0] pending before the abort is granted afterwards.
- Boundaries: len=0 -> 1-cycle pulse; GAP=0 -> next pending grant 1 cycle after q falls; 255-cycle pulse with WIDTH=8, len=255 -> no counter wrap.
- Async reset: assert clr mid-PULSE between clock edges -> q=0 and q_=1 immediately; hold req[2]=1 through release -> pulse starts 2 edges after release.
